// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversample factor and the baud divisor helper.
package uart_pkg;

    localparam int OVERSAMPLE      = 16;
    localparam int DEFAULT_NB_DATA = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_PARITY = 3'd4
    } state_t;

    // Clocks per oversample tick, rounded down.
    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / (OVERSAMPLE * baud);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running divider producing a one-cycle tick at OVERSAMPLE times the baud rate.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 19200
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int DIV   = baud_div(CLK_FREQ, BAUD_RATE);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign o_tick = (cnt_reg == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// 16x oversampling 8N1 UART receiver; define UART_RX_PARITY_EN to add an even-parity bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int NB_DATA   = DEFAULT_NB_DATA,
    parameter int SB_TICK   = 16,
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 19200
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_done,
    output logic               o_frame_err,
    output logic               o_parity_err,
    output logic               o_busy
);

    localparam int S_MAX = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
    localparam int S_W   = $clog2(S_MAX);
    localparam int N_W   = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [S_W-1:0] S_MID  = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(NB_DATA - 1);

    logic tick;

    uart_baud_gen #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) u_baud_gen (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .o_tick (tick)
    );

    // Two-flop synchronizer, preset to the idle-high line level.
    logic [1:0] sync_reg;
    logic       rx_s;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], i_rx};
        end
    end

    assign rx_s = sync_reg[1];

    state_t             state_reg, state_next;
    logic [S_W-1:0]     s_reg, s_next;
    logic [N_W-1:0]     n_reg, n_next;
    logic [NB_DATA-1:0] shift_reg, shift_next;
    logic [NB_DATA-1:0] data_reg, data_next;
    logic               done_reg, done_next;
    logic               ferr_reg, ferr_next;
`ifdef UART_RX_PARITY_EN
    logic               par_bad_reg, par_bad_next;
    logic               perr_reg, perr_next;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg   <= ST_IDLE;
            s_reg       <= '0;
            n_reg       <= '0;
            shift_reg   <= '0;
            data_reg    <= '0;
            done_reg    <= 1'b0;
            ferr_reg    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_reg <= 1'b0;
            perr_reg    <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            s_reg       <= s_next;
            n_reg       <= n_next;
            shift_reg   <= shift_next;
            data_reg    <= data_next;
            done_reg    <= done_next;
            ferr_reg    <= ferr_next;
`ifdef UART_RX_PARITY_EN
            par_bad_reg <= par_bad_next;
            perr_reg    <= perr_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        s_next       = s_reg;
        n_next       = n_reg;
        shift_next   = shift_reg;
        data_next    = data_reg;
        done_next    = 1'b0;
        ferr_next    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_next = par_bad_reg;
        perr_next    = 1'b0;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (!rx_s) begin
                    s_next     = '0;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (s_reg == S_MID) begin
                        if (!rx_s) begin
                            s_next     = '0;
                            n_next     = '0;
                            state_next = ST_DATA;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (s_reg == S_LAST) begin
                        shift_next = {rx_s, shift_reg[NB_DATA-1:1]};
                        s_next     = '0;
                        if (n_reg == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_next = ST_PARITY;
`else
                            state_next = ST_STOP;
`endif
                        end else begin
                            n_next = n_reg + 1'b1;
                        end
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    if (s_reg == S_LAST) begin
                        // Even parity: an odd total of ones marks the word bad.
                        par_bad_next = ^{shift_reg, rx_s};
                        s_next       = '0;
                        state_next   = ST_STOP;
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (s_reg == S_STOP) begin
                        if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                            if (par_bad_reg) begin
                                perr_next = 1'b1;
                            end else begin
                                done_next = 1'b1;
                                data_next = shift_reg;
                            end
`else
                            done_next = 1'b1;
                            data_next = shift_reg;
`endif
                        end else begin
                            ferr_next = 1'b1;
                        end
                        state_next = ST_IDLE;
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign o_data      = data_reg;
    assign o_done      = done_reg;
    assign o_frame_err = ferr_reg;
    assign o_busy      = (state_reg != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = perr_reg;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule
